// File: rtl/tlc_pkg.sv
// Shared types and phase encoding for the traffic-light phase sequencer.
package tlc_pkg;

    localparam int NUM_APPROACH = 4;

    typedef logic [1:0] approach_t;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_e;

endpackage

// File: rtl/tlc_rr_select.sv
// Round-robin next-approach picker: first requesting approach after the
// current one, wrapping to the current one last; plain rotation if nobody asks.
module tlc_rr_select
    import tlc_pkg::*;
(
    input  approach_t                i_state,
    input  logic [NUM_APPROACH-1:0]  i_demand,
    output approach_t                o_next
);

    always_comb begin
        // NOTE: o_next gets a default before the loop so no path leaves it unassigned (no latch).
        o_next = i_state + approach_t'(1);
        // Scan from lowest to highest priority so the nearest requester wins.
        for (int k = NUM_APPROACH; k >= 1; k--) begin
            if (i_demand[i_state + approach_t'(k)]) begin
                o_next = i_state + approach_t'(k);
            end
        end
    end

endmodule

// File: rtl/tlc_phase_sequencer.sv
// Tick-timed GREEN/YELLOW/ALL-RED sequencer driving the lamp decoder's approach index.
// Optional emergency preemption is compiled in with `define TLC_PREEMPT_EN.
module tlc_phase_sequencer
    import tlc_pkg::*;
#(
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 4,
    parameter int T_ALLRED = 2,
    parameter int CNT_W    = 8
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic [NUM_APPROACH-1:0]  demand,
    output logic [1:0]               state,
    output logic [1:0]               phase,
    output logic                     phase_start,
    output logic [CNT_W-1:0]         remaining
`ifdef TLC_PREEMPT_EN
    ,
    input  logic                     preempt,
    input  logic [1:0]               preempt_dir,
    output logic                     preempt_active
`endif
);

    localparam logic [CNT_W-1:0] L_GREEN  = CNT_W'(T_GREEN  - 1);
    localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] L_ALLRED = CNT_W'(T_ALLRED - 1);

    approach_t         r_state;
    phase_e            r_phase;
    logic              r_phase_start;
    logic [CNT_W-1:0]  r_remaining;

    approach_t         w_next;
    approach_t         w_target;
    logic              w_other_req;

    tlc_rr_select u_rr_select (
        .i_state  (r_state),
        .i_demand (demand),
        .o_next   (w_next)
    );

    // The picker returns a requesting approach other than the current one
    // exactly when someone else is waiting.
    assign w_other_req = (w_next != r_state) && demand[w_next];

`ifdef TLC_PREEMPT_EN
    logic r_preempt_active;
    assign w_target       = preempt ? preempt_dir : w_next;
    assign preempt_active = r_preempt_active;
`else
    assign w_target = w_next;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= 2'b11;
            r_phase       <= PH_ALLRED;
            r_remaining   <= L_ALLRED;
            r_phase_start <= 1'b0;
`ifdef TLC_PREEMPT_EN
            r_preempt_active <= 1'b0;
`endif
        end else begin
            r_phase_start <= 1'b0;
`ifdef TLC_PREEMPT_EN
            r_preempt_active <= preempt;
            // Preemption acts every clock; yellow and all-red still run their full time.
            if (preempt && (r_phase == PH_GREEN)) begin
                if (r_state == preempt_dir) begin
                    r_remaining <= L_GREEN;
                end else begin
                    r_phase       <= PH_YELLOW;
                    r_remaining   <= L_YELLOW;
                    r_phase_start <= 1'b1;
                end
            end else if (tick) begin
`else
            if (tick) begin
`endif
                if (r_remaining != '0) begin
                    r_remaining <= r_remaining - CNT_W'(1);
                end else begin
                    case (r_phase)
                        PH_GREEN: begin
                            if (w_other_req) begin
                                r_phase       <= PH_YELLOW;
                                r_remaining   <= L_YELLOW;
                                r_phase_start <= 1'b1;
                            end else begin
                                r_remaining   <= L_GREEN;
                            end
                        end
                        PH_YELLOW: begin
                            r_phase       <= PH_ALLRED;
                            r_remaining   <= L_ALLRED;
                            r_phase_start <= 1'b1;
                        end
                        PH_ALLRED: begin
                            r_state       <= w_target;
                            r_phase       <= PH_GREEN;
                            r_remaining   <= L_GREEN;
                            r_phase_start <= 1'b1;
                        end
                        default: begin
                            r_phase       <= PH_ALLRED;
                            r_remaining   <= L_ALLRED;
                            r_phase_start <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign state       = r_state;
    assign phase       = r_phase;
    assign phase_start = r_phase_start;
    assign remaining   = r_remaining;

endmodule
